// File: rtl/pg_carry_resolver_if.sv
// Request/result bundle for the carry resolver: P/G vectors and carry-in in, carry vector and block P/G out.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the master raises in_valid/out_ready, the slave raises in_ready/out_valid.
interface pg_carry_resolver_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   carry;
    logic             cout;
    logic             blk_p;
    logic             blk_g;
    logic             busy;

    modport master (
        output in_valid, p_in, g_in, cin, out_ready,
        input  in_ready, out_valid, carry, cout, blk_p, blk_g, busy
    );

    modport slave (
        input  in_valid, p_in, g_in, cin, out_ready,
        output in_ready, out_valid, carry, cout, blk_p, blk_g, busy
    );
endinterface

// File: rtl/pg_carry_resolver.sv
// Multi-cycle carry-lookahead resolver: one GROUP-bit group of carries per clock, plus block P/G for cascading.
// Latency: out_valid rises WIDTH/GROUP cycles after the accepting edge.
// Backpressure: result held stable in DONE until out_ready; no new request accepted until then.
module pg_carry_resolver #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pg_carry_resolver_if.slave    bus
);
    localparam int NG = WIDTH / GROUP;
    localparam int KW = $clog2(NG + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH:0]   r_carry;
    logic [KW-1:0]    r_k;
    logic             r_run_carry;
    logic             r_run_gen;
    logic             r_run_prop;
    logic             r_blk_p;
    logic             r_blk_g;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [GROUP-1:0] w_gp;
    logic [GROUP-1:0] w_gg;
    logic [GROUP:0]   w_gc;
    logic [GROUP:0]   w_gn;
    logic             w_gprop;
    logic             w_last;

    // Select the current group's P/G and ripple both the real carry and the cin=0 generate chain through it.
    always_comb begin
        logic c_run;
        logic c_gen;
        w_gp = '0;
        w_gg = '0;
        w_gc = '0;
        w_gn = '0;
        for (int i = 0; i < NG; i++) begin
            if (r_k == KW'(i)) begin
                w_gp = r_p[i*GROUP +: GROUP];
                w_gg = r_g[i*GROUP +: GROUP];
            end
        end
        c_run   = r_run_carry;
        c_gen   = r_run_gen;
        w_gc[0] = c_run;
        w_gn[0] = c_gen;
        for (int j = 0; j < GROUP; j++) begin
            c_run     = w_gg[j] | (w_gp[j] & c_run);
            c_gen     = w_gg[j] | (w_gp[j] & c_gen);
            w_gc[j+1] = c_run;
            w_gn[j+1] = c_gen;
        end
        w_gprop = &w_gp;
        w_last  = (r_k == KW'(NG - 1));
    end

    // Control FSM and all datapath registers; outputs are registered so they hold across backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_g         <= '0;
            r_carry     <= '0;
            r_k         <= '0;
            r_run_carry <= 1'b0;
            r_run_gen   <= 1'b0;
            r_run_prop  <= 1'b0;
            r_blk_p     <= 1'b0;
            r_blk_g     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_p         <= bus.p_in;
                        r_g         <= bus.g_in;
                        r_carry[0]  <= bus.cin;
                        r_run_carry <= bus.cin;
                        r_run_gen   <= 1'b0;
                        r_run_prop  <= 1'b1;
                        r_k         <= '0;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    for (int i = 0; i < NG; i++) begin
                        if (r_k == KW'(i)) begin
                            r_carry[i*GROUP+1 +: GROUP] <= w_gc[GROUP:1];
                        end
                    end
                    r_run_carry <= w_gc[GROUP];
                    r_run_gen   <= w_gn[GROUP];
                    r_run_prop  <= r_run_prop & w_gprop;
                    r_k         <= r_k + KW'(1);
                    if (w_last) begin
                        r_blk_p     <= r_run_prop & w_gprop;
                        r_blk_g     <= w_gn[GROUP];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.carry     = r_carry;
    assign bus.cout      = r_carry[WIDTH];
    assign bus.blk_p     = r_blk_p;
    assign bus.blk_g     = r_blk_g;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_pg_carry_resolver.sv
// Directed bench for pg_carry_resolver at WIDTH=16, GROUP=4.
// Checks reset state, latency, carry/blk results, backpressure hold and mid-operation reset.
// Expected values come from hand-computed constants and a bit-serial ripple model.
module tb_pg_carry_resolver;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int NG    = WIDTH / GROUP;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   lat;

    pg_carry_resolver_if #(.WIDTH(WIDTH)) bus_if ();

    pg_carry_resolver #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_carry(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                                                 input logic c0);
        logic [WIDTH:0] c;
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) c[i+1] = g[i] | (p[i] & c[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic accept(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g, input logic c);
        int n;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("accept_ready", {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.p_in     = p;
        bus_if.g_in     = g;
        bus_if.cin      = c;
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.p_in     = ~p;
        bus_if.g_in     = ~g;
        bus_if.cin      = ~c;
    endtask

    // Count cycles from the accepting edge until out_valid, with a cycle budget.
    task automatic wait_result(output int n);
        n = 0;
        while (bus_if.out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic full_check(input string tag, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                              input logic c);
        logic [WIDTH:0] ec;
        logic [WIDTH:0] eg;
        int n;
        ec = ref_carry(p, g, c);
        eg = ref_carry(p, g, 1'b0);
        accept(p, g, c);
        wait_result(n);
        check({tag, "_lat"}, n, NG);
        check({tag, "_carry"}, {15'd0, bus_if.carry}, {15'd0, ec});
        check({tag, "_cout"}, {31'd0, bus_if.cout}, {31'd0, ec[WIDTH]});
        check({tag, "_blkp"}, {31'd0, bus_if.blk_p}, {31'd0, &p});
        check({tag, "_blkg"}, {31'd0, bus_if.blk_g}, {31'd0, eg[WIDTH]});
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] rp;
        logic [WIDTH-1:0] rg;
        logic             rc;
        logic [WIDTH:0]   rexp;
        checks   = 0;
        failures = 0;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.p_in      = '0;
        bus_if.g_in      = '0;
        bus_if.cin       = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_carry", {15'd0, bus_if.carry}, 32'd0);
        check("rst_cout", {31'd0, bus_if.cout}, 32'd0);
        check("rst_blk", {30'd0, bus_if.blk_p, bus_if.blk_g}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);

        // Propagate chain
        accept(16'hFFFF, 16'h0000, 1'b1);
        check("prop_busy", {31'd0, bus_if.busy}, 32'd1);
        check("prop_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        wait_result(lat);
        check("prop_lat", lat, 32'd4);
        check("prop_carry", {15'd0, bus_if.carry}, 32'h1FFFF);
        check("prop_cout", {31'd0, bus_if.cout}, 32'd1);
        check("prop_blkp", {31'd0, bus_if.blk_p}, 32'd1);
        check("prop_blkg", {31'd0, bus_if.blk_g}, 32'd0);
        tick();
        check("prop_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("prop_idle_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // Generate and kill
        accept(16'h00FF, 16'h0001, 1'b0);
        wait_result(lat);
        check("gk_lat", lat, 32'd4);
        check("gk_carry", {15'd0, bus_if.carry}, 32'h001FE);
        check("gk_cout", {31'd0, bus_if.cout}, 32'd0);
        check("gk_blk", {30'd0, bus_if.blk_p, bus_if.blk_g}, 32'd0);
        tick();

        // Generate without propagate still produces a carry
        accept(16'h0000, 16'h0001, 1'b0);
        wait_result(lat);
        check("gnp_carry", {15'd0, bus_if.carry}, 32'h00002);
        tick();

        // Backpressure: result held for 5 cycles, in_valid pulses ignored
        bus_if.out_ready = 1'b0;
        accept(16'h0F0F, 16'h0101, 1'b1);
        wait_result(lat);
        check("bp_lat", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = (i % 2 == 0);
            bus_if.p_in     = 16'hFFFF;
            bus_if.g_in     = 16'hFFFF;
            bus_if.cin      = 1'b1;
            tick();
            check("bp_valid", {31'd0, bus_if.out_valid}, 32'd1);
            check("bp_carry", {15'd0, bus_if.carry}, 32'h01E1F);
            check("bp_cout", {31'd0, bus_if.cout}, 32'd0);
            check("bp_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check("bp_rel_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("bp_rel_ready", {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        check("bp_no_accept", {31'd0, bus_if.busy}, 32'd0);

        // Mid-operation reset discards the in-flight request
        accept(16'hFFFF, 16'h0000, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("mr_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("mr_carry", {15'd0, bus_if.carry}, 32'd0);
        check("mr_busy", {31'd0, bus_if.busy}, 32'd0);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.out_valid !== 1'b0) lat++;
        end
        check("mr_no_stale", lat, 32'd0);
        accept(16'h8000, 16'h8000, 1'b0);
        wait_result(lat);
        check("mr_new_lat", lat, 32'd4);
        check("mr_new_carry", {15'd0, bus_if.carry}, 32'h10000);
        check("mr_new_cout", {31'd0, bus_if.cout}, 32'd1);
        check("mr_new_blkg", {31'd0, bus_if.blk_g}, 32'd1);
        check("mr_new_blkp", {31'd0, bus_if.blk_p}, 32'd0);
        tick();

        // Directed vectors against the ripple model
        full_check("v_alt", 16'hAAAA, 16'h5555, 1'b0);
        full_check("v_mix", 16'hF0F0, 16'h0F0F, 1'b1);
        full_check("v_allg", 16'h0000, 16'hFFFF, 1'b0);
        full_check("v_zero", 16'h0000, 16'h0000, 1'b1);
        full_check("v_edge", 16'h7FFE, 16'h0001, 1'b0);

        // Random vectors with idle gaps and delayed out_ready
        for (int i = 0; i < 20; i++) begin
            rp   = 16'($urandom);
            rg   = 16'($urandom);
            rc   = 1'($urandom);
            rexp = ref_carry(rp, rg, rc);
            repeat ($urandom_range(0, 2)) tick();
            bus_if.out_ready = 1'b0;
            accept(rp, rg, rc);
            wait_result(lat);
            check("rnd_lat", lat, NG);
            repeat ($urandom_range(0, 3)) tick();
            check("rnd_carry", {15'd0, bus_if.carry}, {15'd0, rexp});
            bus_if.out_ready = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pg_carry_resolver.md
Name: pg_carry_resolver

Overview:
- Multi-cycle carry-lookahead resolver that consumes the per-bit propagate/generate vectors produced by an array of full-adder cells (p = a|b, g = a&b) plus a carry-in.
- Resolves carries one GROUP-bit lookahead group per clock. Returns the full carry vector and block-level P/G for cascading.
- Sits downstream of the adder-cell array. The sum is formed outside the block from the returned carries.

Parameters:
- WIDTH, 16, operand width in bits; must be a positive multiple of GROUP.
- GROUP, 4, bits resolved per cycle (lookahead group size); 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- p_in  input  WIDTH  per-bit propagate
- g_in  input  WIDTH  per-bit generate
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- carry  output  WIDTH+1  carry[i] = carry into bit i; carry[0]=cin, carry[WIDTH]=cout
- cout  output  1  equals carry[WIDTH]
- blk_p  output  1  block propagate = AND of all p_in bits
- blk_g  output  1  block generate = carry out of bit WIDTH-1 when cin=0
- busy  output  1  high in RESOLVE or DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1:
  - state=IDLE; in_ready=1; out_valid=0.
  - carry, cout, blk_p, blk_g, group counter all 0.
  - rst overrides all other inputs, including a reset mid-RESOLVE or DONE. The in-flight request is discarded and no out_valid is produced for it.
- NG = WIDTH/GROUP. Group counter is ceil(log2(NG+1)) bits wide.
- State IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1, capture p_in, g_in, cin. Set carry[0]=cin, run-carry=cin, run-gen=0, run-prop=1, k=0. Go to RESOLVE.
  - While in_valid=0, all registers hold.
- State RESOLVE:
  - in_ready=0, out_valid=0.
  - Each cycle, resolve group k (bits kG..kG+G-1):
    - c[j+1] = g[j] | (p[j] & c[j]), seeded from run-carry.
    - Write carry[kG+1..kG+G].
    - run-carry <= c[kG+G].
    - run-gen follows the same recurrence seeded from run-gen (cin=0 path).
    - run-prop <= run-prop & (AND of group p bits).
  - k increments. When k=NG-1 has been resolved, go to DONE.
  - Latency: out_valid rises exactly NG cycles after the accepting edge (4 for the defaults).
- State DONE:
  - out_valid=1, in_ready=0.
  - carry, cout=carry[WIDTH], blk_p=run-prop, blk_g=run-gen are held stable until handshake.
  - When out_ready=1, go to IDLE. out_valid drops the next cycle.
  - Outputs retain their last values in IDLE; consumers sample only when out_valid=1.
- Handshake rules:
  - in_ready is high only in IDLE, so requests are not accepted while out_valid=1.
  - out_valid and the output data must not change while out_valid=1 and out_ready=0.
  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Throughput: one request per NG+2 cycles minimum (accept, NG resolve cycles, handshake).
- Special cases:
  - GROUP=WIDTH gives a single RESOLVE cycle.
  - p_in/g_in changing after acceptance has no effect on the result.
- Carry semantics follow OR-propagate: g implies p is not required. g=1, p=0 still generates.

Test Plan:
- Propagate chain, WIDTH=16, GROUP=4: p=0xFFFF, g=0x0000, cin=1 -> carry=0x1FFFF, cout=1, blk_p=1, blk_g=0, out_valid exactly 4 cycles after accept.
- Generate and kill: p=0x00FF, g=0x0001, cin=0 -> carry=0x001FE, cout=0, blk_p=0, blk_g=0.
- Backpressure: complete a request, hold out_ready=0 for 5 cycles -> out_valid stays 1, carry/cout stable, in_ready=0 and in_valid pulses ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Mid-operation reset: assert rst 2 cycles after accept -> next cycle state IDLE, out_valid=0, carry=0. No stale result appears afterwards. A new request p=0x8000, g=0x8000, cin=0 -> carry=0x10000, cout=1, blk_g=1.
- Random regression: 1000 random p, g, cin with random in_valid/out_ready gaps, for GROUP in {1, 4, 16} -> carry matches the ripple reference model every time; latency = WIDTH/GROUP cycles; every accepted request produces exactly one result.
